// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and helpers for the MEM/WB pipeline register.
// Carries the legacy defines.v names so existing callers keep their vocabulary.
package mem_wb_pipe_pkg;

  localparam logic       RstEnable    = 1'b0;
  localparam logic       WriteEnable  = 1'b1;
  localparam logic       WriteDisable = 1'b0;
  localparam logic [4:0] NOPRegAddr   = 5'b00000;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic       Stop         = 1'b1;
  localparam logic       NoStop       = 1'b0;

  localparam int unsigned STAGE_MEM = 4;
  localparam int unsigned STAGE_WB  = 5;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2
  } pipe_act_e;

  // Flush beats any stall; a stalled MEM with a free WB must inject a bubble
  // so the last instruction is not written back twice.
  function automatic pipe_act_e decode_act(input logic flush,
                                           input logic mem_stall,
                                           input logic wb_stall);
    pipe_act_e act;
    act = ACT_CAPTURE;
    if (flush)
      act = ACT_BUBBLE;
    else if (mem_stall == Stop)
      act = (wb_stall == NoStop) ? ACT_BUBBLE : ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM -> WB write-back request bundle; the pipe register is the slave.
interface mem_wb_pipe_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_w_reg_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_w_data;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic                  mem_LLbit_we;
  logic                  mem_LLbit_value;
  logic                  mem_cp0_we;
  logic [4:0]            mem_cp0_w_addr;
  logic [DATA_W-1:0]     mem_cp0_w_data;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_w_reg_addr;
  logic                  wb_we;
  logic [DATA_W-1:0]     wb_w_data;
  logic                  wb_whilo;
  logic [DATA_W-1:0]     wb_hi;
  logic [DATA_W-1:0]     wb_lo;
  logic                  wb_LLbit_we;
  logic                  wb_LLbit_value;
  logic                  wb_cp0_we;
  logic [4:0]            wb_cp0_w_addr;
  logic [DATA_W-1:0]     wb_cp0_w_data;

  modport master (
    output mem_valid, mem_w_reg_addr, mem_we, mem_w_data, mem_whilo, mem_hi, mem_lo,
           mem_LLbit_we, mem_LLbit_value, mem_cp0_we, mem_cp0_w_addr, mem_cp0_w_data,
    input  wb_valid, wb_w_reg_addr, wb_we, wb_w_data, wb_whilo, wb_hi, wb_lo,
           wb_LLbit_we, wb_LLbit_value, wb_cp0_we, wb_cp0_w_addr, wb_cp0_w_data
  );

  modport slave (
    input  mem_valid, mem_w_reg_addr, mem_we, mem_w_data, mem_whilo, mem_hi, mem_lo,
           mem_LLbit_we, mem_LLbit_value, mem_cp0_we, mem_cp0_w_addr, mem_cp0_w_data,
    output wb_valid, wb_w_reg_addr, wb_we, wb_w_data, wb_whilo, wb_hi, wb_lo,
           wb_LLbit_we, wb_LLbit_value, wb_cp0_we, wb_cp0_w_addr, wb_cp0_w_data
  );

endinterface

// File: rtl/mem_wb_pipe_field_reg.sv
// One field group of the MEM/WB register: capture, clear to a bubble, or hold.
module pipe_field_reg
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  pipe_act_e    act,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      q <= '0;
    end else begin
      case (act)
        ACT_CAPTURE: q <= d;
        ACT_BUBBLE:  q <= '0;
        default:     q <= q;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register for GPR, HI/LO, LLbit and CP0 write-back requests,
// with stall/flush handling and a retired-instruction counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned MEM_IDX    = STAGE_MEM,
  parameter int unsigned WB_IDX     = STAGE_WB,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  mem_wb_pipe_if.slave       bus,
  output logic [CNT_W-1:0]   instret
);

  pipe_act_e act;
  logic      stall_unused;

  assign act          = decode_act(flush, stall[MEM_IDX], stall[WB_IDX]);
  assign stall_unused = ^stall;

  logic [REG_ADDR_W+DATA_W:0] gpr_q;
  logic [2*DATA_W:0]          hilo_q;
  logic [1:0]                 llbit_q;
  logic [DATA_W+5:0]          cp0_q;
  logic                       valid_q;

  pipe_field_reg #(.W(REG_ADDR_W + DATA_W + 1)) u_gpr (
    .clk(clk), .rst(rst), .act(act),
    .d({bus.mem_we, bus.mem_w_reg_addr, bus.mem_w_data}),
    .q(gpr_q)
  );

  pipe_field_reg #(.W(2 * DATA_W + 1)) u_hilo (
    .clk(clk), .rst(rst), .act(act),
    .d({bus.mem_whilo, bus.mem_hi, bus.mem_lo}),
    .q(hilo_q)
  );

  pipe_field_reg #(.W(2)) u_llbit (
    .clk(clk), .rst(rst), .act(act),
    .d({bus.mem_LLbit_we, bus.mem_LLbit_value}),
    .q(llbit_q)
  );

  pipe_field_reg #(.W(DATA_W + 6)) u_cp0 (
    .clk(clk), .rst(rst), .act(act),
    .d({bus.mem_cp0_we, bus.mem_cp0_w_addr, bus.mem_cp0_w_data}),
    .q(cp0_q)
  );

  pipe_field_reg #(.W(1)) u_valid (
    .clk(clk), .rst(rst), .act(act),
    .d(bus.mem_valid),
    .q(valid_q)
  );

  assign {bus.wb_we, bus.wb_w_reg_addr, bus.wb_w_data}       = gpr_q;
  assign {bus.wb_whilo, bus.wb_hi, bus.wb_lo}                = hilo_q;
  assign {bus.wb_LLbit_we, bus.wb_LLbit_value}               = llbit_q;
  assign {bus.wb_cp0_we, bus.wb_cp0_w_addr, bus.wb_cp0_w_data} = cp0_q;
  assign bus.wb_valid                                        = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable)
      instret <= '0;
    else if (act == ACT_CAPTURE && bus.mem_valid)
      instret <= instret + CNT_W'(1);
  end

endmodule
